// File: rtl/hazard_mdu.sv
// Pipeline hazard unit: operand forwarding, load-use/branch handling, memory
// wait-state stalls and occupancy tracking for a blocking multi-cycle MUL/DIV unit in E.
module hazard_mdu #(
    parameter int unsigned RAW     = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CW      = 4
) (
    input  logic           clk,
    input  logic           reset_x,
    input  logic [RAW-1:0] Di_rs1,
    input  logic [RAW-1:0] Di_rs2,
    input  logic [RAW-1:0] Ei_rs1,
    input  logic [RAW-1:0] Ei_rs2,
    input  logic [RAW-1:0] Ei_rd,
    input  logic [RAW-1:0] Mi_rd,
    input  logic [RAW-1:0] Wi_rd,
    input  logic           Di_jal,
    input  logic           Di_mret,
    input  logic [1:0]     Ei_prePCSrc,
    input  logic [1:0]     Ei_resultSrc,
    input  logic [1:0]     Mi_resultSrc,
    input  logic           Mi_regWrite,
    input  logic           Wi_regWrite,
    input  logic           Ei_mduStart,
    input  logic           Mi_memReq,
    input  logic           Mi_memReady,
    output logic [1:0]     Eo_forwardIn1Src,
    output logic [1:0]     Eo_forwardIn2Src,
    output logic           Fo_stall,
    output logic           Do_stall,
    output logic           Eo_stall,
    output logic           Mo_stall,
    output logic           Do_flush,
    output logic           Eo_flush,
    output logic           Mo_flush,
    output logic           Wo_flush,
    output logic           Eo_mduBusy,
    output logic           Eo_mduDone
);

    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic mem_stall;
    logic lw_stall;
    logic take;
    logic mdu_stall;

    // M has priority over W; a load in M cannot be forwarded, so it selects RF.
    function automatic logic [1:0] fwd_sel(
        input logic [RAW-1:0] rs,
        input logic [RAW-1:0] m_rd,
        input logic [RAW-1:0] w_rd,
        input logic           m_we,
        input logic           w_we,
        input logic [1:0]     m_src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs == '0) begin
            sel = 2'b00;
        end else if ((rs == m_rd) && m_we) begin
            case (m_src)
                2'b00:   sel = 2'b11;
                2'b10:   sel = 2'b10;
                default: sel = 2'b00;
            endcase
        end else if ((rs == w_rd) && w_we) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign Eo_forwardIn1Src = fwd_sel(Ei_rs1, Mi_rd, Wi_rd, Mi_regWrite, Wi_regWrite, Mi_resultSrc);
    assign Eo_forwardIn2Src = fwd_sel(Ei_rs2, Mi_rd, Wi_rd, Mi_regWrite, Wi_regWrite, Mi_resultSrc);

    assign mem_stall = Mi_memReq & ~Mi_memReady;
    assign lw_stall  = (Ei_resultSrc == 2'b01) && (Ei_rd != '0) &&
                       ((Di_rs1 == Ei_rd) || (Di_rs2 == Ei_rd));
    assign take      = (Ei_prePCSrc != 2'b00);
    assign mdu_stall = ((state == IDLE) && Ei_mduStart) || (state == BUSY);

    // MDU occupancy state register
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and stall/flush outputs; a memory stall freezes everything.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        Fo_stall   = 1'b0;
        Do_stall   = 1'b0;
        Eo_stall   = 1'b0;
        Mo_stall   = 1'b0;
        Do_flush   = 1'b0;
        Eo_flush   = 1'b0;
        Mo_flush   = 1'b0;
        Wo_flush   = 1'b0;
        Eo_mduBusy = (state == BUSY);
        Eo_mduDone = (state == DONE);

        if (!mem_stall) begin
            case (state)
                IDLE: begin
                    if (Ei_mduStart) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        if (mem_stall) begin
            Fo_stall = 1'b1;
            Do_stall = 1'b1;
            Eo_stall = 1'b1;
            Mo_stall = 1'b1;
            Wo_flush = 1'b1;
        end else if (mdu_stall) begin
            Fo_stall = 1'b1;
            Do_stall = 1'b1;
            Eo_stall = 1'b1;
            Mo_flush = 1'b1;
        end else begin
            Fo_stall = lw_stall;
            Do_stall = lw_stall;
            Eo_flush = take | lw_stall;
            Do_flush = take | ((Di_jal | Di_mret) & ~lw_stall);
        end
    end

endmodule

// File: tb/tb_hazard_mdu.sv
// Directed self-checking bench for hazard_mdu (default latency plus a MDU_LAT=2 instance).
module tb_hazard_mdu;

    localparam int unsigned RAW = 5;

    logic           clk = 1'b0;
    logic           reset_x;
    logic [RAW-1:0] Di_rs1, Di_rs2, Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd;
    logic           Di_jal, Di_mret;
    logic [1:0]     Ei_prePCSrc, Ei_resultSrc, Mi_resultSrc;
    logic           Mi_regWrite, Wi_regWrite, Ei_mduStart, Mi_memReq, Mi_memReady;

    logic [1:0] fwd1, fwd2, fwd1_b, fwd2_b;
    logic Fo_stall, Do_stall, Eo_stall, Mo_stall, Do_flush, Eo_flush, Mo_flush, Wo_flush;
    logic Eo_mduBusy, Eo_mduDone;
    logic f_st_b, d_st_b, e_st_b, m_st_b, d_fl_b, e_fl_b, m_fl_b, w_fl_b, busy_b, done_b;

    // {F,D,E,M stall | D,E,M,W flush | busy, done}
    logic [9:0] ctl, ctl2;
    assign ctl  = {Fo_stall, Do_stall, Eo_stall, Mo_stall, Do_flush, Eo_flush, Mo_flush, Wo_flush, Eo_mduBusy, Eo_mduDone};
    assign ctl2 = {f_st_b, d_st_b, e_st_b, m_st_b, d_fl_b, e_fl_b, m_fl_b, w_fl_b, busy_b, done_b};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_mdu #(.RAW(RAW), .MDU_LAT(4), .CW(4)) dut (
        .clk(clk), .reset_x(reset_x),
        .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2),
        .Ei_rd(Ei_rd), .Mi_rd(Mi_rd), .Wi_rd(Wi_rd),
        .Di_jal(Di_jal), .Di_mret(Di_mret), .Ei_prePCSrc(Ei_prePCSrc),
        .Ei_resultSrc(Ei_resultSrc), .Mi_resultSrc(Mi_resultSrc),
        .Mi_regWrite(Mi_regWrite), .Wi_regWrite(Wi_regWrite),
        .Ei_mduStart(Ei_mduStart), .Mi_memReq(Mi_memReq), .Mi_memReady(Mi_memReady),
        .Eo_forwardIn1Src(fwd1), .Eo_forwardIn2Src(fwd2),
        .Fo_stall(Fo_stall), .Do_stall(Do_stall), .Eo_stall(Eo_stall), .Mo_stall(Mo_stall),
        .Do_flush(Do_flush), .Eo_flush(Eo_flush), .Mo_flush(Mo_flush), .Wo_flush(Wo_flush),
        .Eo_mduBusy(Eo_mduBusy), .Eo_mduDone(Eo_mduDone)
    );

    hazard_mdu #(.RAW(RAW), .MDU_LAT(2), .CW(4)) dut_lat2 (
        .clk(clk), .reset_x(reset_x),
        .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2),
        .Ei_rd(Ei_rd), .Mi_rd(Mi_rd), .Wi_rd(Wi_rd),
        .Di_jal(Di_jal), .Di_mret(Di_mret), .Ei_prePCSrc(Ei_prePCSrc),
        .Ei_resultSrc(Ei_resultSrc), .Mi_resultSrc(Mi_resultSrc),
        .Mi_regWrite(Mi_regWrite), .Wi_regWrite(Wi_regWrite),
        .Ei_mduStart(Ei_mduStart), .Mi_memReq(Mi_memReq), .Mi_memReady(Mi_memReady),
        .Eo_forwardIn1Src(fwd1_b), .Eo_forwardIn2Src(fwd2_b),
        .Fo_stall(f_st_b), .Do_stall(d_st_b), .Eo_stall(e_st_b), .Mo_stall(m_st_b),
        .Do_flush(d_fl_b), .Eo_flush(e_fl_b), .Mo_flush(m_fl_b), .Wo_flush(w_fl_b),
        .Eo_mduBusy(busy_b), .Eo_mduDone(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Di_rs1 = '0; Di_rs2 = '0; Ei_rs1 = '0; Ei_rs2 = '0;
        Ei_rd = '0; Mi_rd = '0; Wi_rd = '0;
        Di_jal = 1'b0; Di_mret = 1'b0;
        Ei_prePCSrc = 2'b00; Ei_resultSrc = 2'b00; Mi_resultSrc = 2'b00;
        Mi_regWrite = 1'b0; Wi_regWrite = 1'b0;
        Ei_mduStart = 1'b0; Mi_memReq = 1'b0; Mi_memReady = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_x = 1'b0;
        clear_inputs();
        step();
        reset_x = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_x = 1'b0;
        clear_inputs();
        #1;
        n_tests++;
        if ({fwd1, fwd2, ctl} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fwd=%b/%b ctl=%b, expected all 0", fwd1, fwd2, ctl);
        end
        step();
        reset_x = 1'b1;
        step();
        n_tests++;
        if ({fwd1, fwd2, ctl, ctl2} !== 24'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ctl=%b ctl2=%b, expected 0", ctl, ctl2);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        Ei_rs1 = 5'd5; Ei_rs2 = 5'd9; Mi_rd = 5'd5; Mi_regWrite = 1'b1; Mi_resultSrc = 2'b00;
        Wi_rd = 5'd5; Wi_regWrite = 1'b1;
        #1;
        n_tests++;
        if (fwd1 !== 2'b11 || fwd2 !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_m_alu: got %b/%b expected 11/00", fwd1, fwd2);
        end
        Mi_resultSrc = 2'b01;
        #1;
        n_tests++;
        if (fwd1 !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_m_load: got %b expected 00", fwd1);
        end
        Mi_resultSrc = 2'b10;
        #1;
        n_tests++;
        if (fwd1 !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_m_imm: got %b expected 10", fwd1);
        end
        Mi_rd = 5'd6; Ei_rs2 = 5'd6;
        #1;
        n_tests++;
        if (fwd1 !== 2'b01 || fwd2 !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_w: got %b/%b expected 01/10", fwd1, fwd2);
        end
        Wi_regWrite = 1'b0;
        #1;
        n_tests++;
        if (fwd1 !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_w_nowrite: got %b expected 00", fwd1);
        end
        Ei_rs1 = 5'd0; Mi_rd = 5'd0; Wi_rd = 5'd0; Wi_regWrite = 1'b1; Mi_resultSrc = 2'b00;
        #1;
        n_tests++;
        if (fwd1 !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_x0: got %b expected 00", fwd1);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        Ei_resultSrc = 2'b01; Ei_rd = 5'd7; Di_rs2 = 5'd7;
        #1;
        n_tests++;
        if (ctl !== 10'b1100_0100_00) begin
            n_fail++;
            $display("FAIL load_use: got %b expected 1100010000", ctl);
        end
        Ei_rd = 5'd0; Di_rs2 = 5'd0;
        #1;
        n_tests++;
        if (ctl !== 10'b0) begin
            n_fail++;
            $display("FAIL load_use_x0: got %b expected 0", ctl);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_priority();
        clear_inputs();
        Ei_prePCSrc = 2'b01; Mi_memReq = 1'b1; Mi_memReady = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 10'b1111_0001_00) begin
            n_fail++;
            $display("FAIL prio_take_memstall: got %b expected 1111000100", ctl);
        end
        Mi_memReady = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 10'b0000_1100_00) begin
            n_fail++;
            $display("FAIL prio_take_release: got %b expected 0000110000", ctl);
        end
        Mi_memReq = 1'b0; Mi_memReady = 1'b0; Ei_prePCSrc = 2'b00;
        Di_jal = 1'b1; Ei_resultSrc = 2'b01; Ei_rd = 5'd3; Di_rs1 = 5'd3;
        #1;
        n_tests++;
        if (ctl !== 10'b1100_0100_00) begin
            n_fail++;
            $display("FAIL prio_jal_lw: got %b expected 1100010000", ctl);
        end
        Ei_prePCSrc = 2'b10;
        #1;
        n_tests++;
        if (ctl !== 10'b1100_1100_00) begin
            n_fail++;
            $display("FAIL prio_take_lw: got %b expected 1100110000", ctl);
        end
        clear_inputs();
        Di_mret = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 10'b0000_1000_00) begin
            n_fail++;
            $display("FAIL prio_mret: got %b expected 0000100000", ctl);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_mdu_basic();
        logic [9:0] exp [6] = '{10'b1110_0010_00, 10'b1110_0010_10, 10'b1110_0010_10,
                                10'b1110_0010_10, 10'b0000_0000_01, 10'b0000_0000_00};
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            Ei_mduStart = (i < 5);
            #1;
            n_tests++;
            if (ctl !== exp[i]) begin
                n_fail++;
                $display("FAIL mdu_basic c%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_mdu_memstall();
        logic [9:0] exp [8] = '{10'b1110_0010_00, 10'b1110_0010_10, 10'b1111_0001_10,
                                10'b1111_0001_10, 10'b1110_0010_10, 10'b1110_0010_10,
                                10'b0000_0000_01, 10'b0000_0000_00};
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            Ei_mduStart = (i < 7);
            Mi_memReq   = (i == 2) || (i == 3);
            #1;
            n_tests++;
            if (ctl !== exp[i]) begin
                n_fail++;
                $display("FAIL mdu_memstall c%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        // a start held off by a memory stall in IDLE must not begin early
        Ei_mduStart = 1'b1; Mi_memReq = 1'b1;
        #1;
        n_tests++;
        if (ctl !== 10'b1111_0001_00) begin
            n_fail++;
            $display("FAIL mdu_start_memstall: got %b expected 1111000100", ctl);
        end
        step();
        Mi_memReq = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 10'b1110_0010_00) begin
            n_fail++;
            $display("FAIL mdu_start_after_mem: got %b expected 1110001000", ctl);
        end
        reset_pulse();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [11] = '{10'b1110_0010_00, 10'b1110_0010_10, 10'b1110_0010_10,
                                 10'b1110_0010_10, 10'b0000_0000_01, 10'b1110_0010_00,
                                 10'b1110_0010_10, 10'b1110_0010_10, 10'b1110_0010_10,
                                 10'b0000_0000_01, 10'b0000_0000_00};
        clear_inputs();
        for (int i = 0; i < 11; i++) begin
            Ei_mduStart = (i < 10);
            #1;
            n_tests++;
            if (ctl !== exp[i]) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        Ei_mduStart = 1'b1;
        step();
        step();
        n_tests++;
        if (ctl !== 10'b1110_0010_10) begin
            n_fail++;
            $display("FAIL rst_busy_pre: got %b expected 1110001010", ctl);
        end
        reset_x = 1'b0;
        Ei_mduStart = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_busy_async: got %b expected 0", ctl);
        end
        step();
        reset_x = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (ctl !== 10'b0) begin
                n_fail++;
                $display("FAIL rst_busy_after c%0d: got %b expected 0", i, ctl);
            end
        end
    endtask

    task automatic test_lat2();
        logic [9:0] exp [4] = '{10'b1110_0010_00, 10'b1110_0010_10,
                                10'b0000_0000_01, 10'b0000_0000_00};
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            Ei_mduStart = (i < 3);
            #1;
            n_tests++;
            if (ctl2 !== exp[i]) begin
                n_fail++;
                $display("FAIL lat2 c%0d: got %b expected %b", i, ctl2, exp[i]);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_x = 1'b1;
        step();
        test_reset();
        test_forwarding();
        test_load_use();
        test_priority();
        test_mdu_basic();
        test_mdu_memstall();
        test_back_to_back();
        test_reset_mid_busy();
        test_lat2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
